// File: rtl/ide_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ide_pio_sequencer
// Description : ATA PIO strobe sequencer between the 68000 bus decode and the
//               IDE drive. Generates nior/niow with programmable setup,
//               active and recovery phases, stretches the strobe on IORDY
//               with a timeout, and returns DTACK plus a read-data latch
//               enable to the bus-side data path.
// Revision    : 1.0 - initial release
// ============================================================================
module ide_pio_sequencer #(
    parameter int unsigned SETUP_CYC   = 1,
    parameter int unsigned ACTIVE_CYC  = 2,
    parameter int unsigned RECOVER_CYC = 2,
    parameter bit          IORDY_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 7
) (
    input  logic cpuclk7,
    input  logic reset,
    input  logic nas,
    input  logic r_w,
    input  logic ide_sel,
    input  logic iordy,
    input  logic clr_timeout,
    output logic nior,
    output logic niow,
    output logic dtack,
    output logic data_le,
    output logic wr_oe,
    output logic busy,
    output logic timeout
);

    // Phase lengths expressed as "last cycle" counter values.
    localparam logic [CNT_W-1:0] c_SETUP_LAST   = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_ACTIVE_LAST  = CNT_W'(ACTIVE_CYC - 1);
    localparam logic [CNT_W-1:0] c_RECOVER_LAST = CNT_W'(RECOVER_CYC - 1);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACTIVE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_dir;        // 1: read, 0: write
    logic             w_dir_nxt;
    logic             r_nas_q;
    logic             r_iordy_meta;
    logic             r_iordy_s;
    logic             r_timeout;
    logic             w_set_timeout;

    // Register the address strobe once; all access decisions use this copy.
    always_ff @(posedge cpuclk7 or posedge reset) begin
        if (reset) begin
            r_nas_q <= 1'b1;
        end else begin
            r_nas_q <= nas;
        end
    end

    // Two-flop synchroniser for the asynchronous drive IORDY line.
    always_ff @(posedge cpuclk7 or posedge reset) begin
        if (reset) begin
            r_iordy_meta <= 1'b1;
            r_iordy_s    <= 1'b1;
        end else begin
            r_iordy_meta <= iordy;
            r_iordy_s    <= r_iordy_meta;
        end
    end

    // State, phase counter and captured direction.
    always_ff @(posedge cpuclk7 or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dir   <= w_dir_nxt;
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear.
    always_ff @(posedge cpuclk7 or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_set_timeout) begin
            r_timeout <= 1'b1;
        end else if (clr_timeout) begin
            r_timeout <= 1'b0;
        end
    end

    assign timeout = r_timeout;

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
        w_dir_nxt     = r_dir;
        w_set_timeout = 1'b0;
        nior          = 1'b1;
        niow          = 1'b1;
        dtack         = 1'b0;
        data_le       = 1'b0;
        wr_oe         = 1'b0;
        busy          = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy      = 1'b0;
                w_cnt_nxt = '0;
                if (!r_nas_q && ide_sel) begin
                    w_state_nxt = ST_SETUP;
                    w_dir_nxt   = r_w;
                end
            end

            ST_SETUP: begin
                wr_oe = !r_dir;
                if (r_nas_q) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_SETUP_LAST) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end
            end

            ST_ACTIVE: begin
                nior  = !r_dir;
                niow  = r_dir;
                wr_oe = !r_dir;
                if (r_nas_q) begin
                    // Aborted bus cycle: drop the strobe, no data, no DTACK.
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_ACTIVE_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_iordy_s || !IORDY_EN) begin
                        w_state_nxt = ST_HOLD;
                        data_le     = r_dir;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                nior  = !r_dir;
                niow  = r_dir;
                wr_oe = !r_dir;
                if (r_nas_q) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = '0;
                end else if (r_iordy_s) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = '0;
                    data_le     = r_dir;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    // Drive never became ready: complete the access anyway.
                    w_state_nxt   = ST_HOLD;
                    w_cnt_nxt     = '0;
                    w_set_timeout = 1'b1;
                    data_le       = r_dir;
                end
            end

            ST_HOLD: begin
                dtack = 1'b1;
                wr_oe = !r_dir;
                if (r_nas_q) begin
                    w_state_nxt = ST_RECOVER;
                    w_cnt_nxt   = '0;
                end
            end

            ST_RECOVER: begin
                if (r_cnt == c_RECOVER_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ide_pio_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ide_pio_sequencer
// Description : Directed self-checking bench for ide_pio_sequencer with the
//               default timing parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ide_pio_sequencer;

    logic cpuclk7 = 1'b0;
    logic reset   = 1'b1;
    logic nas     = 1'b1;
    logic r_w     = 1'b1;
    logic ide_sel = 1'b1;
    logic iordy   = 1'b1;
    logic clr_timeout = 1'b0;
    logic nior, niow, dtack, data_le, wr_oe, busy, timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed outputs packed as {nior,niow,dtack,data_le,wr_oe,busy,timeout}.
    wire [6:0] w_obs = {nior, niow, dtack, data_le, wr_oe, busy, timeout};

    ide_pio_sequencer dut (
        .cpuclk7     (cpuclk7),
        .reset       (reset),
        .nas         (nas),
        .r_w         (r_w),
        .ide_sel     (ide_sel),
        .iordy       (iordy),
        .clr_timeout (clr_timeout),
        .nior        (nior),
        .niow        (niow),
        .dtack       (dtack),
        .data_le     (data_le),
        .wr_oe       (wr_oe),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 cpuclk7 = ~cpuclk7;

    task automatic tick;
        @(posedge cpuclk7);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b", w_obs, 7'b1100000);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", w_obs, 7'b1100000);
        end
    endtask

    task automatic test_read;
        logic [6:0] exp;
        nas = 1'b0; r_w = 1'b1; iordy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            case (i)
                0:       exp = 7'b1100000;  // nas being registered
                1:       exp = 7'b1100010;  // SETUP
                2:       exp = 7'b0100010;  // ACTIVE cycle 1
                3:       exp = 7'b0101010;  // ACTIVE last, latch data
                4, 5:    exp = 7'b1110010;  // HOLD
                6, 7:    exp = 7'b1100010;  // RECOVER
                default: exp = 7'b1100000;  // IDLE
            endcase
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL read_cycle%0d: got %b expected %b", i, w_obs, exp);
            end
            if (i == 4) nas = 1'b1;
        end
    endtask

    task automatic test_write_iordy;
        logic [6:0] exp;
        iordy = 1'b0;
        repeat (3) tick();
        nas = 1'b0; r_w = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            case (i)
                0:                   exp = 7'b1100000;
                1:                   exp = 7'b1100110;  // SETUP, drivers on
                2, 3, 4, 5, 6, 7, 8: exp = 7'b1000110;  // niow low 2+5 cycles
                9, 10:               exp = 7'b1110110;  // HOLD, data still driven
                11, 12:              exp = 7'b1100010;  // RECOVER
                default:             exp = 7'b1100000;
            endcase
            n_checks++;
            if (w_obs !== exp) begin
                n_fail++;
                $display("FAIL write_cycle%0d: got %b expected %b", i, w_obs, exp);
            end
            if (i == 6) iordy = 1'b1;
            if (i == 9) nas = 1'b1;
        end
        r_w = 1'b1;
    endtask

    task automatic test_timeout;
        int  low_cnt = 0;
        int  le_cnt  = 0;
        int  le_bad  = 0;
        bit  done    = 1'b0;
        iordy = 1'b0;
        repeat (3) tick();
        nas = 1'b0; r_w = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (dtack) begin
                done = 1'b1;
            end else begin
                if (!nior) low_cnt++;
                if (data_le) le_cnt++;
                if (data_le && nior) le_bad++;
            end
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout_dtack: dtack never seen within 200 cycles");
        end
        n_checks++;
        if (low_cnt !== 66) begin
            n_fail++;
            $display("FAIL timeout_strobe_len: got %0d expected %0d", low_cnt, 66);
        end
        n_checks++;
        if (le_cnt !== 1 || le_bad !== 0) begin
            n_fail++;
            $display("FAIL timeout_data_le: got %0d pulses (%0d outside nior) expected 1 (0)", le_cnt, le_bad);
        end
        n_checks++;
        if ({nior, timeout} !== 2'b11) begin
            n_fail++;
            $display("FAIL timeout_flag_set: got nior,timeout=%b expected 11", {nior, timeout});
        end
        iordy = 1'b1;
        nas   = 1'b1;
        repeat (4) tick();
        n_checks++;
        if ({busy, timeout} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_sticky: got busy,timeout=%b expected 01", {busy, timeout});
        end
        clr_timeout = 1'b1;
        tick();
        clr_timeout = 1'b0;
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b expected 0", timeout);
        end
    endtask

    task automatic test_back_to_back;
        bit got = 1'b0;
        nas = 1'b0; r_w = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (dtack) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL b2b_first_dtack: dtack never seen within 20 cycles");
        end
        nas = 1'b1;
        tick();
        tick();
        n_checks++;
        if (w_obs !== 7'b1100010) begin
            n_fail++;
            $display("FAIL b2b_recover0: got %b expected %b", w_obs, 7'b1100010);
        end
        nas = 1'b0;
        tick();
        n_checks++;
        if (w_obs !== 7'b1100010) begin
            n_fail++;
            $display("FAIL b2b_recover1: got %b expected %b", w_obs, 7'b1100010);
        end
        tick();
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL b2b_idle: got %b expected %b", w_obs, 7'b1100000);
        end
        tick();
        n_checks++;
        if (w_obs !== 7'b1100010) begin
            n_fail++;
            $display("FAIL b2b_setup: got %b expected %b", w_obs, 7'b1100010);
        end
        tick();
        n_checks++;
        if (w_obs !== 7'b0100010) begin
            n_fail++;
            $display("FAIL b2b_second_nior: got %b expected %b", w_obs, 7'b0100010);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (dtack) got = 1'b1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL b2b_second_dtack: dtack never seen within 20 cycles");
        end
        nas = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_abort_setup;
        nas = 1'b0; r_w = 1'b1;
        tick();
        nas = 1'b1;
        tick();
        n_checks++;
        if (w_obs !== 7'b1100010) begin
            n_fail++;
            $display("FAIL abort_setup_in_setup: got %b expected %b", w_obs, 7'b1100010);
        end
        tick();
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL abort_setup_idle: got %b expected %b", w_obs, 7'b1100000);
        end
        tick();
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL abort_setup_stays_idle: got %b expected %b", w_obs, 7'b1100000);
        end
    endtask

    task automatic test_abort_active;
        nas = 1'b0; r_w = 1'b1;
        tick();
        tick();
        tick();
        nas = 1'b1;
        tick();
        n_checks++;
        if (w_obs !== 7'b0100010) begin
            n_fail++;
            $display("FAIL abort_active_no_le: got %b expected %b", w_obs, 7'b0100010);
        end
        tick();
        n_checks++;
        if (w_obs !== 7'b1100010) begin
            n_fail++;
            $display("FAIL abort_active_recover: got %b expected %b", w_obs, 7'b1100010);
        end
        tick();
        tick();
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL abort_active_idle: got %b expected %b", w_obs, 7'b1100000);
        end
    endtask

    task automatic test_no_sel;
        ide_sel = 1'b0;
        nas     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (w_obs !== 7'b1100000) begin
                n_fail++;
                $display("FAIL no_sel_cycle%0d: got %b expected %b", i, w_obs, 7'b1100000);
            end
        end
        nas     = 1'b1;
        ide_sel = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_active;
        nas = 1'b0; r_w = 1'b1;
        tick();
        tick();
        tick();
        n_checks++;
        if ({nior, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_mid_in_active: got nior,busy=%b expected 01", {nior, busy});
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL rst_mid_immediate: got %b expected %b", w_obs, 7'b1100000);
        end
        nas = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (w_obs !== 7'b1100000) begin
            n_fail++;
            $display("FAIL rst_mid_after: got %b expected %b", w_obs, 7'b1100000);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_iordy();
        test_timeout();
        test_back_to_back();
        test_abort_setup();
        test_abort_active();
        test_no_sel();
        test_reset_mid_active();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
